pipe_hazard_ctl: RTL and testbench



---
 rtl/riscv_pkg.sv | 29 ++
 rtl/hz_fwd_sel.sv | 35 +++
 rtl/pipe_hazard_ctl.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the 5-stage RISC-V pipeline hazard control.
//   fwd_e      : EX operand source select (00 reg, 01 ex_mem, 10 mem_wb)
//   mc_state_e : multi-cycle EX unit sequencing states
//   hz_stage_t : per-stage shadow control flags. Register indices are
//                carried alongside because their width is a module parameter.
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10
    } fwd_e;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_e;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic is_load;
        logic is_mc;
    } hz_stage_t;

endpackage

// File: rtl/hz_fwd_sel.sv
// ----------------------------------------------------------------------------
// hz_fwd_sel
// Single-operand forwarding comparator. The younger EX/MEM producer wins over
// MEM/WB; x0 is never forwarded.
// Ports:
//   src        in  REG_IDX_W  source register index of the operand in EX
//   mem_fwd_ok in  1          MEM holds a valid non-load register writer
//   mem_rd     in  REG_IDX_W  MEM destination index
//   wb_fwd_ok  in  1          WB holds a valid register writer
//   wb_rd      in  REG_IDX_W  WB destination index
//   sel        out fwd_e      operand source select
// ----------------------------------------------------------------------------
module hz_fwd_sel
    import riscv_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] src,
    input  logic                 mem_fwd_ok,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 wb_fwd_ok,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output fwd_e                 sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_fwd_ok && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_EX_MEM;
        end else if (wb_fwd_ok && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctl
// Central hazard controller for the 5-stage pipeline. Shadows EX/MEM/WB
// destination info and drives stall/flush/bubble controls, EX forwarding
// selects and the start/done handshake of a multi-cycle EX unit.
//
// Parameters:
//   REG_IDX_W    register index width
//   MC_FIXED_LAT 0: wait for mc_done; N>=1: internal counter, mc_done ignored
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   id_valid                     ID holds a real instruction
//   id_rs1/id_rs2, id_uses_rs*   ID sources and whether they are read
//   id_rd, id_regwrite           ID destination and write enable
//   id_is_load, id_is_mc         ID instruction class (load wins if both)
//   ex_redirect                  EX resolved a taken branch/jump
//   mc_done                      multi-cycle unit result ready
//   pc_stall, if_id_stall        hold PC / IF-ID
//   if_id_flush                  zero IF-ID
//   id_ex_bubble                 load a bubble into ID-EX
//   ex_hold                      freeze ID-EX, bubble into EX-MEM
//   mc_start                     one-cycle start pulse to the multi-cycle unit
//   fwd_a, fwd_b                 EX operand source selects (fwd_b also store data)
//   perf_stall_cnt/perf_flush_cnt  only with PIPE_HAZARD_PERF_EN defined
// ----------------------------------------------------------------------------
module pipe_hazard_ctl
    import riscv_pkg::*;
#(
    parameter int REG_IDX_W    = 5,
    parameter int MC_FIXED_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 id_is_mc,
    input  logic                 ex_redirect,
    input  logic                 mc_done,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 ex_hold,
    output logic                 mc_start,
    output logic [1:0]           fwd_a,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
`endif
    output logic [1:0]           fwd_b
);

    localparam int CNT_W = $clog2(MC_FIXED_LAT + 2);

    hz_stage_t            ex_q, mem_q, wb_q, id_st;
    logic [REG_IDX_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q, ex_rs1_q, ex_rs2_q;
    mc_state_e            mc_state_q;
    logic [CNT_W-1:0]     mc_cnt_q;
    logic                 ex_mc, mc_release, load_use, redirect;
    fwd_e                 fwd_a_sel, fwd_b_sel;

    // is_mc is not consulted past EX, nor is_load past MEM.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{mem_q.is_mc, wb_q.is_load, wb_q.is_mc};

    assign ex_mc      = ex_q.valid & ex_q.is_mc;
    assign mc_release = (MC_FIXED_LAT == 0) ? mc_done : (mc_cnt_q == CNT_W'(1));

    assign load_use = id_valid & ex_q.valid & ex_q.is_load & (ex_rd_q != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd_q)));
    assign redirect = ex_q.valid & ~ex_q.is_mc & ex_redirect;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        mc_start = 1'b0;
        ex_hold  = 1'b0;
        case (mc_state_q)
            MC_IDLE: begin
                if (ex_mc) begin
                    mc_start = 1'b1;
                    ex_hold  = 1'b1;
                end
            end
            MC_BUSY: ex_hold = ~mc_release;
            default: ex_hold = 1'b0;
        endcase
    end

    // Priority: multi-cycle hold, then redirect, then load-use.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (ex_hold) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    // A load that is also flagged multi-cycle is treated as a plain load.
    assign id_st = '{valid:    id_valid & ~id_ex_bubble & ~if_id_flush,
                     regwrite: id_regwrite,
                     is_load:  id_is_load,
                     is_mc:    id_is_mc & ~id_is_load};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            ex_rd_q  <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else if (ex_hold) begin
            mem_q.valid <= 1'b0;
            wb_q        <= mem_q;
            wb_rd_q     <= mem_rd_q;
        end else begin
            ex_q     <= id_st;
            ex_rd_q  <= id_rd;
            ex_rs1_q <= id_rs1;
            ex_rs2_q <= id_rs2;
            mem_q    <= ex_q;
            mem_rd_q <= ex_rd_q;
            wb_q     <= mem_q;
            wb_rd_q  <= mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_state_q <= MC_IDLE;
            mc_cnt_q   <= '0;
        end else begin
            case (mc_state_q)
                MC_IDLE: begin
                    if (ex_mc) begin
                        mc_state_q <= MC_BUSY;
                        mc_cnt_q   <= CNT_W'(MC_FIXED_LAT);
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_q <= mc_cnt_q - CNT_W'(1);
                    end
                    if (mc_release) begin
                        mc_state_q <= MC_IDLE;
                    end
                end
                default: mc_state_q <= MC_IDLE;
            endcase
        end
    end

    hz_fwd_sel #(.REG_IDX_W(REG_IDX_W)) u_fwd_a (
        .src        (ex_rs1_q),
        .mem_fwd_ok (mem_q.valid & mem_q.regwrite & ~mem_q.is_load),
        .mem_rd     (mem_rd_q),
        .wb_fwd_ok  (wb_q.valid & wb_q.regwrite),
        .wb_rd      (wb_rd_q),
        .sel        (fwd_a_sel)
    );

    hz_fwd_sel #(.REG_IDX_W(REG_IDX_W)) u_fwd_b (
        .src        (ex_rs2_q),
        .mem_fwd_ok (mem_q.valid & mem_q.regwrite & ~mem_q.is_load),
        .mem_rd     (mem_rd_q),
        .wb_fwd_ok  (wb_q.valid & wb_q.regwrite),
        .wb_rd      (wb_rd_q),
        .sel        (fwd_b_sel)
    );

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (if_id_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctl
// Directed bench for pipe_hazard_ctl. Two instances share the ID-side inputs:
// dut (handshake multi-cycle mode) and dut_fx (MC_FIXED_LAT=3), the latter
// held in its own reset until its phase. Expected output vectors are queued
// as each step is driven and popped when the outputs are sampled.
// Vector layout: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
//                 ex_hold, mc_start, fwd_a[1:0], fwd_b[1:0]}
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctl;

    logic       clk = 1'b0;
    logic       rst_n, rst_fx_n;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load, id_is_mc;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, mc_done;

    logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mc_start;
    logic [1:0] fwd_a, fwd_b;
    logic       fx_pc_stall, fx_if_id_stall, fx_if_id_flush, fx_id_ex_bubble, fx_ex_hold, fx_mc_start;
    logic [1:0] fx_fwd_a, fx_fwd_b;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, fx_perf_stall_cnt, fx_perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        bit         fx;
        logic [9:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.REG_IDX_W(5), .MC_FIXED_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
        .ex_redirect(ex_redirect), .mc_done(mc_done),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mc_start(mc_start),
        .fwd_a(fwd_a),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .fwd_b(fwd_b)
    );

    pipe_hazard_ctl #(.REG_IDX_W(5), .MC_FIXED_LAT(3)) dut_fx (
        .clk(clk), .rst_n(rst_fx_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
        .ex_redirect(ex_redirect), .mc_done(mc_done),
        .pc_stall(fx_pc_stall), .if_id_stall(fx_if_id_stall), .if_id_flush(fx_if_id_flush),
        .id_ex_bubble(fx_id_ex_bubble), .ex_hold(fx_ex_hold), .mc_start(fx_mc_start),
        .fwd_a(fx_fwd_a),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cnt(fx_perf_stall_cnt), .perf_flush_cnt(fx_perf_flush_cnt),
`endif
        .fwd_b(fx_fwd_b)
    );

    function automatic logic [9:0] ev(bit pc, bit ifs, bit fl, bit bb, bit eh, bit ms,
                                      logic [1:0] a, logic [1:0] b);
        return {pc, ifs, fl, bb, eh, ms, a, b};
    endfunction

    task automatic id_set(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input bit u1, input bit u2,
                          input bit rw, input bit ld, input bit mc);
        id_valid = v;   id_rd = rd;       id_rs1 = rs1;     id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw;
        id_is_load = ld;  id_is_mc = mc;
    endtask

    task automatic push(input string tag, input bit fx, input logic [9:0] v);
        exp_t e;
        e.tag = tag; e.fx = fx; e.v = v;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t       e;
        logic [9:0] o;
        e = sb.pop_front();
        o = e.fx ? {fx_pc_stall, fx_if_id_stall, fx_if_id_flush, fx_id_ex_bubble,
                    fx_ex_hold, fx_mc_start, fx_fwd_a, fx_fwd_b}
                 : {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                    ex_hold, mc_start, fwd_a, fwd_b};
        n_checks++;
        assert (o === e.v) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, o, e.v);
        end
    endtask

    // Inputs are applied just after a falling edge; outputs sampled 1 ns later.
    task automatic step(input string tag, input bit fx, input logic [9:0] v);
        push(tag, fx, v);
        #1;
        chk();
        @(negedge clk);
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with hostile inputs: every output must still be zero.
        rst_n = 1'b0; rst_fx_n = 1'b0; ex_redirect = 1'b1; mc_done = 1'b1;
        id_set(1, 5, 5, 5, 1, 1, 1, 1, 0);
        #2;
        push("reset_d", 0, '0);
        push("reset_fx", 1, '0);
        chk(); chk();
        @(negedge clk);
        rst_n = 1'b1; ex_redirect = 1'b0; mc_done = 1'b0;

        // Load-use: lw x5 ; add x6,x5,x1
        id_set(1, 5, 2, 0, 1, 0, 1, 1, 0); step("lw_x5_in_id",      0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 6, 5, 1, 1, 1, 1, 0, 0); step("load_use_stall",   0, ev(1,1,0,1,0,0,2'b00,2'b00));
                                           step("load_use_1_bubble",0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fwd_a_wb_load",    0, ev(0,0,0,0,0,0,2'b10,2'b00));

        // ALU chains: add x3 ; sub x4,x3,x3 ; add x0 ; sub x7,x0,x0
        id_set(1, 3, 1, 2, 1, 1, 1, 0, 0); step("add_x3",           0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 4, 3, 3, 1, 1, 1, 0, 0); step("sub_x4_in_id",     0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 0, 1, 2, 1, 1, 1, 0, 0); step("fwd_ex_mem_x3",    0, ev(0,0,0,0,0,0,2'b01,2'b01));
        id_set(1, 7, 0, 0, 1, 1, 1, 0, 0); step("add_x0_in_ex",     0, ev(0,0,0,0,0,0,2'b00,2'b00));
        // add x9 ; add x9 ; sub x10,x9,x9 (both MEM and WB match: MEM wins)
        id_set(1, 9, 1, 1, 1, 1, 1, 0, 0); step("rd_x0_no_fwd",     0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 9, 2, 2, 1, 1, 1, 0, 0); step("add_x9_b",         0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1,10, 9, 9, 1, 1, 1, 0, 0); step("sub_x10_in_id",    0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fwd_mem_over_wb",  0, ev(0,0,0,0,0,0,2'b01,2'b01));

        // Redirect in EX while ID has a load-use hazard on it
        id_set(1, 5, 2, 0, 1, 0, 1, 1, 0); step("lw_x5_again",      0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 6, 5, 1, 1, 1, 1, 0, 0); ex_redirect = 1'b1;
                                           step("redirect_over_lu", 0, ev(0,0,1,1,0,0,2'b00,2'b00));
        id_set(1, 1, 0, 0, 0, 0, 1, 0, 0); step("flushed_not_in_ex",0, ev(0,0,0,0,0,0,2'b00,2'b00));

        // Handshake multi-cycle: mul x11,x1,x2 then mul x12,x11,x11 back-to-back
        ex_redirect = 1'b0; mc_done = 1'b1;
        id_set(1,11, 1, 2, 1, 1, 1, 0, 1); step("mc_done_idle_ign", 0, ev(0,0,0,0,0,0,2'b00,2'b00));
        mc_done = 1'b0; ex_redirect = 1'b1;
        id_set(1,12,11,11, 1, 1, 1, 0, 1); step("mc_start",         0, ev(1,1,0,0,1,1,2'b01,2'b00));
        ex_redirect = 1'b0;                step("mc_hold_1",        0, ev(1,1,0,0,1,0,2'b10,2'b00));
                                           step("mc_hold_2",        0, ev(1,1,0,0,1,0,2'b00,2'b00));
                                           step("mc_hold_3",        0, ev(1,1,0,0,1,0,2'b00,2'b00));
        mc_done = 1'b1;                    step("mc_release",       0, ev(0,0,0,0,0,0,2'b00,2'b00));
        mc_done = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mc_b2b_start",     0, ev(1,1,0,0,1,1,2'b01,2'b01));
        mc_done = 1'b1;                    step("mc_min_2_cycles",  0, ev(0,0,0,0,0,0,2'b10,2'b10));
        mc_done = 1'b0;

        // Second load-use through rs2, then non-stalling boundary cases
        id_set(1, 5, 2, 0, 1, 0, 1, 1, 0); step("lw_x5_third",      0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 8, 3, 5, 1, 1, 0, 0, 0); step("load_use_rs2",     0, ev(1,1,0,1,0,0,2'b00,2'b00));
                                           step("store_bubble",     0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 7, 2, 0, 1, 0, 1, 1, 0); step("fwd_b_store_wb",   0, ev(0,0,0,0,0,0,2'b00,2'b10));
        id_set(1, 8, 7, 7, 0, 0, 1, 0, 0); step("unused_src_no_lu", 0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 0, 2, 0, 1, 0, 1, 1, 0); step("lw_x0_in_id",      0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(1, 9, 0, 0, 1, 1, 1, 0, 0); step("load_rd_x0_no_lu", 0, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_PERF_EN
        // Stall cycles: 2 load-use + 4 + 1 multi-cycle hold; flush cycles: 1.
        chk_val("perf_stall_cnt", perf_stall_cnt, 32'd7);
        chk_val("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif
                                           step("idle_tail",        0, ev(0,0,0,0,0,0,2'b00,2'b00));

        // Fixed-latency instance (MC_FIXED_LAT=3): mc_done held high throughout
        rst_fx_n = 1'b1; mc_done = 1'b1;
        id_set(1,13, 1, 2, 1, 1, 1, 0, 1); step("fx_empty",         1, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fx_mc_start",      1, ev(1,1,0,0,1,1,2'b00,2'b00));
                                           step("fx_hold_1",        1, ev(1,1,0,0,1,0,2'b00,2'b00));
                                           step("fx_hold_2",        1, ev(1,1,0,0,1,0,2'b00,2'b00));
                                           step("fx_release",       1, ev(0,0,0,0,0,0,2'b00,2'b00));
        mc_done = 1'b0;
        id_set(1,14, 3, 4, 1, 1, 1, 0, 1); step("fx_mul_in_id",     1, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fx_start_2",       1, ev(1,1,0,0,1,1,2'b00,2'b00));
        push("fx_hold_pre_reset", 1, ev(1,1,0,0,1,0,2'b00,2'b00));
        #1;
        chk();
        // Asynchronous reset mid-BUSY, away from any clock edge
        #2;
        rst_fx_n = 1'b0;
        #1;
        push("fx_async_reset", 1, '0);
        chk();
`ifdef PIPE_HAZARD_PERF_EN
        chk_val("fx_perf_stall_rst", fx_perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_fx_n = 1'b1;
        id_set(1,15, 1, 2, 1, 1, 1, 0, 1); step("fx_after_reset",   1, ev(0,0,0,0,0,0,2'b00,2'b00));
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fx_idle_after_rst",1, ev(1,1,0,0,1,1,2'b00,2'b00));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
